gate_truth_table_checker: RTL and testbench

//   Self-running stimulus/response engine for a 2-input gate bank (and, or, not, nand, nor, xor, xnor).

---
 rtl/gate_check_pkg.sv | 29 ++
 rtl/gate_truth_table_checker.sv | 125 ++++++++++++
 tb/tb_gate_truth_table_checker.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gate_check_pkg.sv
// Shared state encoding, gate bit positions and golden truth model
// for the 2-input gate bank checker.
package gate_check_pkg;

  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, SAMPLE, DONE} state_t;

  localparam int G_AND  = 0;
  localparam int G_OR   = 1;
  localparam int G_NOT  = 2;
  localparam int G_NAND = 3;
  localparam int G_NOR  = 4;
  localparam int G_XOR  = 5;
  localparam int G_XNOR = 6;

  // The single-input inverter in the bank is fed from stimulus a.
  function automatic logic [6:0] expected_gates(input logic a, input logic b);
    logic [6:0] g;
    g         = '0;
    g[G_AND]  = a & b;
    g[G_OR]   = a | b;
    g[G_NOT]  = ~a;
    g[G_NAND] = ~(a & b);
    g[G_NOR]  = ~(a | b);
    g[G_XOR]  = a ^ b;
    g[G_XNOR] = ~(a ^ b);
    return g;
  endfunction

endpackage

// File: rtl/gate_truth_table_checker.sv
// Walks a 2-input gate bank through all four input vectors, checks each
// response against the golden model and reports fail mask, error count and pass.
module gate_truth_table_checker
  import gate_check_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] gate_in,
  output logic       a_out,
  output logic       b_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [6:0] fail_mask,
  output logic [2:0] err_count,
  output logic [1:0] first_fail_vec
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

  state_t     r_state;
  logic [1:0] r_vec;
  logic [3:0] r_cnt;
  logic       r_a;
  logic       r_b;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic [6:0] r_failMask;
  logic [2:0] r_errCount;
  logic [1:0] r_firstFailVec;

  logic [6:0] w_golden;
  logic [6:0] w_mismatch;

  assign w_golden   = expected_gates(r_a, r_b);
  assign w_mismatch = gate_in ^ w_golden;

  // Stimulus changes on the edge leaving DRIVE, so the bank gets exactly
  // SETTLE_CYCLES cycles before SAMPLE looks at its outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_vec          <= '0;
      r_cnt          <= '0;
      r_a            <= 1'b0;
      r_b            <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_pass         <= 1'b0;
      r_failMask     <= '0;
      r_errCount     <= '0;
      r_firstFailVec <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_a <= 1'b0;
          r_b <= 1'b0;
          if (start) begin
            r_failMask     <= '0;
            r_errCount     <= '0;
            r_firstFailVec <= '0;
            r_pass         <= 1'b0;
            r_vec          <= '0;
            r_busy         <= 1'b1;
            r_state        <= DRIVE;
          end
        end
        DRIVE: begin
          r_a     <= r_vec[1];
          r_b     <= r_vec[0];
          r_cnt   <= SETTLE_LOAD;
          r_state <= (SETTLE_LOAD != 4'd0) ? SETTLE : SAMPLE;
        end
        SETTLE: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= SAMPLE;
          end
        end
        SAMPLE: begin
          r_failMask <= r_failMask | w_mismatch;
          if (|w_mismatch) begin
            r_errCount <= r_errCount + 3'd1;
            if (r_errCount == 3'd0) begin
              r_firstFailVec <= r_vec;
            end
          end
          // pass is decided here so it is already valid while done is high
          if (r_vec == 2'd3) begin
            r_pass  <= ((r_failMask | w_mismatch) == 7'd0);
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_vec   <= r_vec + 2'd1;
            r_state <= DRIVE;
          end
        end
        DONE: begin
          r_a     <= 1'b0;
          r_b     <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign a_out          = r_a;
  assign b_out          = r_b;
  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_pass;
  assign fail_mask      = r_failMask;
  assign err_count      = r_errCount;
  assign first_fail_vec = r_firstFailVec;

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Scoreboard bench for gate_truth_table_checker: three instances (settle 1, 0, 3)
// each driving a behavioural gate bank with selectable fault and output delay.
module tb_gate_truth_table_checker;

  typedef struct packed {
    logic [6:0] mask;
    logic [2:0] err;
    logic [1:0] ffv;
    logic       pass;
    logic       full;
  } exp_t;

  // Truth table columns indexed by {a,b}.
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NOT  = 4'b0011;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_XNOR = 4'b1001;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] startV;
  wire  [2:0] doneV, busyV, passV, aV, bV;
  wire  [6:0] maskV [3];
  wire  [2:0] errV [3];
  wire  [1:0] ffvV [3];
  wire  [6:0] gateIn [3];
  logic [1:0] hist [3][4];
  int         fault [3];
  int         dly [3];

  exp_t sb[$];
  int   testsRun = 0;
  int   testsFailed = 0;

  always #5 clk = ~clk;

  function automatic logic [6:0] idealGates(input logic [1:0] v);
    logic [6:0] g;
    g = {TT_XNOR[v], TT_XOR[v], TT_NOR[v], TT_NAND[v], TT_NOT[v], TT_OR[v], TT_AND[v]};
    return g;
  endfunction

  // fault 1: and output stuck at 1; fault 2: xor and xnor wires swapped
  function automatic logic [6:0] bankOut(input logic [1:0] v, input int f);
    logic [6:0] g;
    g = idealGates(v);
    if (f == 1) g[0] = 1'b1;
    if (f == 2) g = {g[5], g[6], g[4:0]};
    return g;
  endfunction

  function automatic exp_t modelRun(input int f);
    exp_t       e;
    logic [6:0] mm;
    e      = '0;
    e.full = 1'b1;
    for (int v = 0; v < 4; v++) begin
      mm = bankOut(2'(v), f) ^ idealGates(2'(v));
      if (mm != 7'd0) begin
        if (e.err == 3'd0) e.ffv = 2'(v);
        e.err = e.err + 3'd1;
      end
      e.mask = e.mask | mm;
    end
    e.pass = (e.mask == 7'd0);
    return e;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      hist[k][0] <= {aV[k], bV[k]};
      for (int i = 1; i < 4; i++) hist[k][i] <= hist[k][i-1];
    end
  end

  for (genvar k = 0; k < 3; k++) begin : g_bank
    assign gateIn[k] = bankOut((dly[k] == 0) ? {aV[k], bV[k]} : hist[k][2'(dly[k] - 1)], fault[k]);
  end

  gate_truth_table_checker #(.SETTLE_CYCLES(1)) u0 (
    .clk(clk), .rst(rst), .start(startV[0]), .gate_in(gateIn[0]),
    .a_out(aV[0]), .b_out(bV[0]), .busy(busyV[0]), .done(doneV[0]), .pass(passV[0]),
    .fail_mask(maskV[0]), .err_count(errV[0]), .first_fail_vec(ffvV[0]));

  gate_truth_table_checker #(.SETTLE_CYCLES(0)) u1 (
    .clk(clk), .rst(rst), .start(startV[1]), .gate_in(gateIn[1]),
    .a_out(aV[1]), .b_out(bV[1]), .busy(busyV[1]), .done(doneV[1]), .pass(passV[1]),
    .fail_mask(maskV[1]), .err_count(errV[1]), .first_fail_vec(ffvV[1]));

  gate_truth_table_checker #(.SETTLE_CYCLES(3)) u2 (
    .clk(clk), .rst(rst), .start(startV[2]), .gate_in(gateIn[2]),
    .a_out(aV[2]), .b_out(bV[2]), .busy(busyV[2]), .done(doneV[2]), .pass(passV[2]),
    .fail_mask(maskV[2]), .err_count(errV[2]), .first_fail_vec(ffvV[2]));

  task automatic pulseStart(input int sel, input bit hold);
    @(negedge clk);
    startV[sel] = 1'b1;
    @(posedge clk);
    if (!hold) #1 startV[sel] = 1'b0;
  endtask

  // Counts edges after the accepting edge until done is seen, tallying
  // stimulus values observed in each SAMPLE cycle against the vector order.
  task automatic waitDone(input int sel, input int s, input int budget,
                          output int edges, output int walkErrs);
    edges    = 0;
    walkErrs = 0;
    do begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if ((edges % (s + 2)) == (s + 1) && edges < 4 * (s + 2) &&
          {aV[sel], bV[sel]} !== 2'(edges / (s + 2))) walkErrs++;
    end while (doneV[sel] !== 1'b1 && edges < budget);
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    startV = '0;
    for (int k = 0; k < 3; k++) begin
      fault[k] = 0;
      dly[k]   = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      testsRun++;
      if ({busyV[k], doneV[k], passV[k], aV[k], bV[k], maskV[k], errV[k], ffvV[k]} !== 17'd0) begin
        testsFailed++;
        $display("[TB] FAIL reset_outputs u%0d: got %h expected 0", k,
                 {busyV[k], doneV[k], passV[k], aV[k], bV[k], maskV[k], errV[k], ffvV[k]});
      end
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    testsRun++;
    if (busyV !== 3'b000) begin
      testsFailed++;
      $display("[TB] FAIL idle_after_reset: busy got %b expected 000", busyV);
    end
  endtask

  task automatic test_ideal();
    int   e, w;
    exp_t x;
    fault[0] = 0;
    sb.push_back(modelRun(0));
    pulseStart(0, 1'b0);
    waitDone(0, 1, 100, e, w);
    x = sb.pop_front();
    testsRun++;
    if (e !== 12) begin testsFailed++; $display("[TB] FAIL ideal_latency: got %0d expected 12", e); end
    testsRun++;
    if (w !== 0) begin testsFailed++; $display("[TB] FAIL ideal_walk: got %0d bad vectors expected 0", w); end
    testsRun++;
    if (passV[0] !== x.pass) begin testsFailed++; $display("[TB] FAIL ideal_pass: got %b expected %b", passV[0], x.pass); end
    testsRun++;
    if ({maskV[0], errV[0]} !== {x.mask, x.err}) begin
      testsFailed++;
      $display("[TB] FAIL ideal_results: got mask %h err %0d expected mask %h err %0d", maskV[0], errV[0], x.mask, x.err);
    end
    @(negedge clk);
    testsRun++;
    if ({doneV[0], aV[0], bV[0]} !== 3'b000) begin
      testsFailed++;
      $display("[TB] FAIL ideal_after_done: done/a/b got %b expected 000", {doneV[0], aV[0], bV[0]});
    end
  endtask

  task automatic test_fault(input int f, input string tag);
    int   e, w;
    exp_t x;
    fault[0] = f;
    sb.push_back(modelRun(f));
    pulseStart(0, 1'b0);
    waitDone(0, 1, 100, e, w);
    x = sb.pop_front();
    testsRun++;
    if (e !== 12) begin testsFailed++; $display("[TB] FAIL %s_latency: got %0d expected 12", tag, e); end
    testsRun++;
    if ({maskV[0], errV[0], ffvV[0], passV[0]} !== {x.mask, x.err, x.ffv, x.pass}) begin
      testsFailed++;
      $display("[TB] FAIL %s_results: got mask %h err %0d ffv %0d pass %b expected mask %h err %0d ffv %0d pass %b",
               tag, maskV[0], errV[0], ffvV[0], passV[0], x.mask, x.err, x.ffv, x.pass);
    end
    repeat (3) @(negedge clk);
    testsRun++;
    if ({maskV[0], errV[0], passV[0]} !== {x.mask, x.err, x.pass}) begin
      testsFailed++;
      $display("[TB] FAIL %s_held: got mask %h err %0d expected mask %h err %0d", tag, maskV[0], errV[0], x.mask, x.err);
    end
    fault[0] = 0;
  endtask

  task automatic test_ignore_start();
    int   e, spurious;
    exp_t x;
    sb.push_back(modelRun(0));
    pulseStart(0, 1'b0);
    e = 0;
    do begin
      @(posedge clk);
      e++;
      @(negedge clk);
      startV[0] = (e == 4);
    end while (doneV[0] !== 1'b1 && e < 100);
    startV[0] = 1'b0;
    x = sb.pop_front();
    testsRun++;
    if (e !== 12) begin testsFailed++; $display("[TB] FAIL ignore_latency: got %0d expected 12", e); end
    testsRun++;
    if (passV[0] !== x.pass) begin testsFailed++; $display("[TB] FAIL ignore_pass: got %b expected %b", passV[0], x.pass); end
    spurious = 0;
    repeat (20) begin
      @(negedge clk);
      if (doneV[0] === 1'b1 || busyV[0] === 1'b1) spurious++;
    end
    testsRun++;
    if (spurious !== 0) begin testsFailed++; $display("[TB] FAIL ignore_extra_run: got %0d busy cycles expected 0", spurious); end
  endtask

  // 13 quiet cycles separate the two done pulses: DONE -> IDLE -> DRIVE -> ...
  task automatic test_back_to_back();
    int   e1, e2, w;
    exp_t x;
    fault[0] = 1;
    sb.push_back(modelRun(1));
    sb.push_back(modelRun(0));
    pulseStart(0, 1'b1);
    waitDone(0, 1, 100, e1, w);
    fault[0] = 0;
    x = sb.pop_front();
    testsRun++;
    if (e1 !== 12) begin testsFailed++; $display("[TB] FAIL b2b_first_latency: got %0d expected 12", e1); end
    testsRun++;
    if ({maskV[0], errV[0], passV[0]} !== {x.mask, x.err, x.pass}) begin
      testsFailed++;
      $display("[TB] FAIL b2b_first_results: got mask %h err %0d pass %b expected mask %h err %0d pass %b",
               maskV[0], errV[0], passV[0], x.mask, x.err, x.pass);
    end
    waitDone(0, 1, 100, e2, w);
    startV[0] = 1'b0;
    x = sb.pop_front();
    testsRun++;
    if (e2 !== 14) begin testsFailed++; $display("[TB] FAIL b2b_gap: got %0d edges expected 14", e2); end
    testsRun++;
    if ({maskV[0], errV[0], passV[0]} !== {x.mask, x.err, x.pass}) begin
      testsFailed++;
      $display("[TB] FAIL b2b_second_results: got mask %h err %0d pass %b expected mask %h err %0d pass %b",
               maskV[0], errV[0], passV[0], x.mask, x.err, x.pass);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_mid_reset();
    int   e, w, spurious;
    exp_t x;
    fault[0] = 1;
    pulseStart(0, 1'b0);
    repeat (7) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    testsRun++;
    if ({busyV[0], doneV[0], passV[0], aV[0], bV[0], maskV[0], errV[0], ffvV[0]} !== 17'd0) begin
      testsFailed++;
      $display("[TB] FAIL midreset_outputs: got %h expected 0",
               {busyV[0], doneV[0], passV[0], aV[0], bV[0], maskV[0], errV[0], ffvV[0]});
    end
    spurious = 0;
    repeat (20) begin
      @(negedge clk);
      if (doneV[0] === 1'b1 || busyV[0] === 1'b1) spurious++;
    end
    testsRun++;
    if (spurious !== 0) begin testsFailed++; $display("[TB] FAIL midreset_no_done: got %0d active cycles expected 0", spurious); end
    fault[0] = 0;
    sb.push_back(modelRun(0));
    pulseStart(0, 1'b0);
    waitDone(0, 1, 100, e, w);
    x = sb.pop_front();
    testsRun++;
    if (e !== 12 || passV[0] !== x.pass || errV[0] !== x.err) begin
      testsFailed++;
      $display("[TB] FAIL midreset_rerun: got latency %0d pass %b err %0d expected 12 %b %0d", e, passV[0], errV[0], x.pass, x.err);
    end
  endtask

  task automatic test_settle_variants();
    int   e, w;
    exp_t x;
    sb.push_back(modelRun(0));
    pulseStart(1, 1'b0);
    waitDone(1, 0, 100, e, w);
    x = sb.pop_front();
    testsRun++;
    if (e !== 8 || w !== 0) begin testsFailed++; $display("[TB] FAIL settle0_timing: got latency %0d walk errs %0d expected 8 0", e, w); end
    testsRun++;
    if (passV[1] !== x.pass) begin testsFailed++; $display("[TB] FAIL settle0_pass: got %b expected %b", passV[1], x.pass); end

    dly[2] = 3;
    sb.push_back(modelRun(0));
    pulseStart(2, 1'b0);
    waitDone(2, 3, 100, e, w);
    x = sb.pop_front();
    testsRun++;
    if (e !== 20 || w !== 0) begin testsFailed++; $display("[TB] FAIL settle3_timing: got latency %0d walk errs %0d expected 20 0", e, w); end
    testsRun++;
    if ({passV[2], maskV[2]} !== {x.pass, x.mask}) begin
      testsFailed++;
      $display("[TB] FAIL settle3_delay3: got pass %b mask %h expected pass %b mask %h", passV[2], maskV[2], x.pass, x.mask);
    end

    dly[2] = 4;
    x      = '0;
    sb.push_back(x);
    pulseStart(2, 1'b0);
    waitDone(2, 3, 100, e, w);
    x = sb.pop_front();
    testsRun++;
    if (e !== 20) begin testsFailed++; $display("[TB] FAIL settle3_delay4_latency: got %0d expected 20", e); end
    testsRun++;
    if (passV[2] !== x.pass) begin testsFailed++; $display("[TB] FAIL settle3_delay4_pass: got %b expected %b", passV[2], x.pass); end
    dly[2] = 0;
  endtask

  initial begin
    test_reset();
    test_ideal();
    test_fault(1, "and_stuck1");
    test_fault(2, "xor_swap");
    test_ignore_start();
    test_back_to_back();
    test_mid_reset();
    test_settle_variants();
    testsRun++;
    if (sb.size() !== 0) begin testsFailed++; $display("[TB] FAIL scoreboard_drain: got %0d left expected 0", sb.size()); end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
